// File: rtl/cache_read_interface_mc.sv
// Multi-channel cache-to-stream read engine: per-channel transfer slots, round-robin
// arbitration onto one SRAM read port, RD_LAT-aligned return path, per-channel beat FIFOs.
module cache_read_interface_mc #(
   parameter int NUM_CH    = 2,
   parameter int ADDR_BITS = 10,
   parameter int LEN_BITS  = 8,
   parameter int CL_E      = 4,
   parameter int IWIDTH    = 128,
   parameter int CWIDTH    = 32,
   parameter int BUF_LEN   = 4,
   parameter int ID_LEN    = 2,
   parameter int RD_LAT    = 1
) (
   input  logic                                      clk,
   input  logic                                      rst,
   output logic [NUM_CH-1:0]                         OUT_ready,
   input  logic [NUM_CH-1:0]                         IN_valid,
   input  logic [NUM_CH*ID_LEN-1:0]                  IN_id,
   input  logic [NUM_CH*LEN_BITS-1:0]                IN_len,
   input  logic [NUM_CH*ADDR_BITS-1:0]               IN_addr,
   input  logic [NUM_CH-1:0]                         IN_mmio,
   input  logic [NUM_CH*32-1:0]                      IN_mmioData,
   input  logic [NUM_CH-1:0]                         IN_ready,
   output logic [NUM_CH-1:0]                         OUT_valid,
   output logic [NUM_CH*ID_LEN-1:0]                  OUT_id,
   output logic [NUM_CH*IWIDTH-1:0]                  OUT_data,
   output logic [NUM_CH-1:0]                         OUT_last,
   input  logic                                      IN_CACHE_ready,
   output logic                                      OUT_CACHE_ce,
   output logic                                      OUT_CACHE_we,
   output logic [ADDR_BITS-1:0]                      OUT_CACHE_addr,
   input  logic [CWIDTH-1:0]                         IN_CACHE_data,
   output logic                                      OUT_cacheReadValid,
   output logic [ID_LEN-1:0]                         OUT_cacheReadId,
   output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] OUT_cacheReadCh
);

   localparam int WNUM = IWIDTH / CWIDTH;
   localparam int LW   = (WNUM > 1) ? $clog2(WNUM) : 1;
   localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PW   = (BUF_LEN > 1) ? $clog2(BUF_LEN) : 1;
   localparam int CW   = $clog2(BUF_LEN + 1);
   localparam int RW   = $clog2(BUF_LEN * WNUM + 1) + 1;

   typedef struct packed {
      logic [ID_LEN-1:0]    id;
      logic [ADDR_BITS-1:0] addr;
      logic [LEN_BITS-1:0]  len;
      logic                 mmio;
      logic [31:0]          mmd;
   } slot_t;

   typedef struct packed {
      logic [CHW-1:0]    ch;
      logic [ID_LEN-1:0] id;
      logic              last;
      logic              mmio;
      logic [31:0]       mmd;
      logic [LW-1:0]     lane;
   } meta_t;

   function automatic logic [IWIDTH-1:0] place_word(input logic [CWIDTH-1:0] w,
                                                    input logic [LW-1:0] lane);
      return IWIDTH'(w) << (int'(lane) * CWIDTH);
   endfunction

   slot_t               cur_s [NUM_CH];
   slot_t               nxt_s [NUM_CH];
   slot_t               req_s [NUM_CH];
   logic [LEN_BITS-1:0] cur_prog [NUM_CH];
   logic [NUM_CH-1:0]   cur_vld, nxt_vld, retire, accept, elig, push, pop;
   logic [CHW-1:0]      rr, gnt, idx;
   logic                gnt_any, issue, issue_last;
   logic [LW-1:0]       issue_lane;
   logic [RW-1:0]       issue_w;
   slot_t               sel;
   logic [LEN_BITS-1:0] sel_prog;
   logic [CL_E-1:0]     wrap_off;

   // Words reserved against FIFO space: in flight plus accumulated, with last/MMIO
   // words reserving the remainder of their beat so a short beat never overflows.
   logic [RW-1:0]       resv [NUM_CH];
   logic [CW-1:0]       cnt [NUM_CH];
   logic [PW-1:0]       wr_ptr [NUM_CH];
   logic [PW-1:0]       rd_ptr [NUM_CH];
   logic [IWIDTH-1:0]   acc [NUM_CH];
   logic [IWIDTH-1:0]   push_data [NUM_CH];
   logic [IWIDTH-1:0]   fifo_data [NUM_CH][BUF_LEN];
   logic [ID_LEN-1:0]   fifo_id [NUM_CH][BUF_LEN];
   logic                fifo_last [NUM_CH][BUF_LEN];

   logic [RD_LAT-1:0]   vld_p;
   meta_t               meta_p [RD_LAT];
   meta_t               ret;
   logic                ret_vld;
   logic [IWIDTH-1:0]   ins;

   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         req_s[c] = {IN_id[c*ID_LEN +: ID_LEN], IN_addr[c*ADDR_BITS +: ADDR_BITS],
                     IN_len[c*LEN_BITS +: LEN_BITS], IN_mmio[c], IN_mmioData[c*32 +: 32]};
         elig[c]  = cur_vld[c] &&
                    (((RW'(BUF_LEN) - RW'(cnt[c])) * RW'(WNUM)) > resv[c]);
      end
   end

   always_comb begin
      gnt_any = 1'b0;
      gnt     = '0;
      idx     = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         idx = CHW'((int'(rr) + k) % NUM_CH);
         if (!gnt_any && elig[idx]) begin
            gnt_any = 1'b1;
            gnt     = idx;
         end
      end
   end

   always_comb begin
      sel        = cur_s[gnt];
      sel_prog   = cur_prog[gnt];
      issue      = gnt_any && (sel.mmio || IN_CACHE_ready);
      issue_last = sel.mmio || (sel_prog == sel.len);
      issue_lane = sel.mmio ? '0 : LW'(sel_prog & LEN_BITS'(WNUM - 1));
      issue_w    = (sel.mmio || issue_last) ? RW'(WNUM) - RW'(issue_lane) : RW'(1);
      wrap_off   = sel.addr[CL_E-1:0] + sel_prog[CL_E-1:0];
      for (int c = 0; c < NUM_CH; c++) begin
         retire[c]    = issue && (gnt == CHW'(c)) && issue_last;
         OUT_ready[c] = !nxt_vld[c] || retire[c];
         accept[c]    = IN_valid[c] && OUT_ready[c];
      end
   end

   assign OUT_CACHE_ce       = !(gnt_any && !sel.mmio);
   assign OUT_CACHE_we       = 1'b1;
   assign OUT_CACHE_addr     = {sel.addr[ADDR_BITS-1:CL_E], wrap_off};
   assign OUT_cacheReadValid = issue;
   assign OUT_cacheReadId    = sel.id;
   assign OUT_cacheReadCh    = gnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_vld <= '0;
         nxt_vld <= '0;
         rr      <= '0;
      end else begin
         if (issue)
            rr <= (gnt == CHW'(NUM_CH - 1)) ? '0 : gnt + CHW'(1);
         for (int c = 0; c < NUM_CH; c++) begin
            if (retire[c]) begin
               cur_prog[c] <= '0;
               if (nxt_vld[c]) begin
                  cur_s[c]   <= nxt_s[c];
                  nxt_vld[c] <= accept[c];
                  if (accept[c])
                     nxt_s[c] <= req_s[c];
               end else begin
                  cur_vld[c] <= accept[c];
                  if (accept[c])
                     cur_s[c] <= req_s[c];
               end
            end else begin
               if (issue && (gnt == CHW'(c)))
                  cur_prog[c] <= cur_prog[c] + LEN_BITS'(1);
               if (accept[c]) begin
                  if (!cur_vld[c]) begin
                     cur_vld[c]  <= 1'b1;
                     cur_s[c]    <= req_s[c];
                     cur_prog[c] <= '0;
                  end else begin
                     nxt_vld[c] <= 1'b1;
                     nxt_s[c]   <= req_s[c];
                  end
               end
            end
         end
      end
   end

   // Stage p0..p(RD_LAT-1): read metadata rides alongside the SRAM latency
   always_ff @(posedge clk) begin
      if (rst)
         vld_p <= '0;
      else begin
         vld_p[0] <= issue;
         for (int s = 1; s < RD_LAT; s++)
            vld_p[s] <= vld_p[s-1];
      end
   end

   always_ff @(posedge clk) begin
      meta_p[0] <= '{ch: gnt, id: sel.id, last: issue_last, mmio: sel.mmio,
                     mmd: sel.mmd, lane: issue_lane};
      for (int s = 1; s < RD_LAT; s++)
         meta_p[s] <= meta_p[s-1];
   end

   // Return stage: data aligned with metadata, assemble into beats
   always_comb begin
      ret_vld = vld_p[RD_LAT-1];
      ret     = meta_p[RD_LAT-1];
      ins     = place_word(IN_CACHE_data, ret.lane);
      for (int c = 0; c < NUM_CH; c++) begin
         push[c]      = ret_vld && (ret.ch == CHW'(c)) &&
                        (ret.mmio || ret.last || (ret.lane == LW'(WNUM - 1)));
         push_data[c] = ret.mmio ? IWIDTH'(ret.mmd) : (acc[c] | ins);
      end
   end

   always_comb begin
      OUT_valid = '0;
      OUT_id    = '0;
      OUT_data  = '0;
      OUT_last  = '0;
      pop       = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         OUT_valid[c]                  = (cnt[c] != '0);
         OUT_id[c*ID_LEN +: ID_LEN]    = fifo_id[c][rd_ptr[c]];
         OUT_data[c*IWIDTH +: IWIDTH]  = fifo_data[c][rd_ptr[c]];
         OUT_last[c]                   = fifo_last[c][rd_ptr[c]];
         pop[c]                        = OUT_valid[c] && IN_ready[c];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            acc[c]    <= '0;
            resv[c]   <= '0;
            cnt[c]    <= '0;
            wr_ptr[c] <= '0;
            rd_ptr[c] <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (ret_vld && (ret.ch == CHW'(c)) && !ret.mmio)
               acc[c] <= push[c] ? '0 : (acc[c] | ins);
            resv[c] <= resv[c] + ((issue && (gnt == CHW'(c))) ? issue_w : '0)
                               - (push[c] ? RW'(WNUM) : '0);
            cnt[c]  <= cnt[c] + CW'(push[c]) - CW'(pop[c]);
            if (push[c])
               wr_ptr[c] <= (wr_ptr[c] == PW'(BUF_LEN - 1)) ? '0 : wr_ptr[c] + PW'(1);
            if (pop[c])
               rd_ptr[c] <= (rd_ptr[c] == PW'(BUF_LEN - 1)) ? '0 : rd_ptr[c] + PW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (push[c]) begin
            fifo_data[c][wr_ptr[c]] <= push_data[c];
            fifo_id[c][wr_ptr[c]]   <= ret.id;
            fifo_last[c][wr_ptr[c]] <= ret.last;
         end
      end
   end

endmodule
